instr_dispatch: RTL

INSTR_DISPATCH -- requirements
Module: instr_dispatch

---
 rtl/instr_dispatch_pkg.sv | 43 ++++
 rtl/instr_fifo.sv | 52 +++++
 rtl/instr_dispatch.sv | 103 ++++++++++
 3 files changed

// File: rtl/instr_dispatch_pkg.sv
// Shared definitions for the instruction dispatcher: word layout, opcodes and FSM states.
package instr_dispatch_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 8;
   localparam int OP_LSB  = 0;
   localparam int A_LSB   = 3;
   localparam int B_LSB   = 11;
   localparam int C_LSB   = 19;
   localparam int RSV_LSB = 27;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_MUL  = 3'b010,
      OP_SMUL = 3'b011,
      OP_DET  = 3'b100,
      OP_TRN  = 3'b101,
      OP_OPP  = 3'b110
   } opcode_e;

   localparam logic [2:0] ILLEGAL_OP = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   // Field order mirrors the word layout, MSB first.
   typedef struct packed {
      logic [4:0]        rsvd;
      logic [ADDR_W-1:0] c;
      logic [ADDR_W-1:0] b;
      logic [ADDR_W-1:0] a;
      logic [2:0]        op;
   } instr_t;

   function automatic instr_t decode(input logic [INSTR_W-1:0] w);
      return instr_t'(w);
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction buffer: power-of-two depth FIFO with show-ahead head output.
module instr_fifo
   import instr_dispatch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = INSTR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rptr, wptr;
   logic [AW:0]      cnt;
   logic             do_push, do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr];

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/instr_dispatch.sv
// Pulls words from the buffer, issues them to the coprocessor and waits for done or timeout.
module instr_dispatch
   import instr_dispatch_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int TIMEOUT    = 1023
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   output logic [2:0]         opcode,
   output logic [ADDR_W-1:0]  andressA,
   output logic [ADDR_W-1:0]  andressB,
   output logic [ADDR_W-1:0]  andressC,
   output logic               start,
   input  logic               done,
   output logic               busy,
   output logic               err_illegal,
   output logic               err_timeout,
   output logic [7:0]         issue_count
);

   localparam int             CW    = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  TLAST = CW'(TIMEOUT - 1);

   state_e             state;
   logic [CW-1:0]      wcnt;
   logic [INSTR_W-1:0] fifo_dout;
   logic               fifo_full, fifo_empty, pop;
   instr_t             head;
   logic               unused_rsvd;

   assign head        = decode(fifo_dout);
   assign unused_rsvd = ^head.rsvd;
   assign pop         = (state == S_IDLE) && !fifo_empty;
   assign in_ready    = !fifo_full;
   assign busy        = (state != S_IDLE) || !fifo_empty;

   instr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INSTR_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid && in_ready),
      .pop   (pop),
      .din   (in_instr),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         wcnt        <= '0;
         opcode      <= '0;
         andressA    <= '0;
         andressB    <= '0;
         andressC    <= '0;
         start       <= 1'b0;
         err_illegal <= 1'b0;
         err_timeout <= 1'b0;
         issue_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  // An illegal word is consumed and dropped; the next one is tried next cycle.
                  if (head.op == ILLEGAL_OP) begin
                     err_illegal <= 1'b1;
                  end else begin
                     opcode   <= head.op;
                     andressA <= head.a;
                     andressB <= head.b;
                     andressC <= head.c;
                     start    <= 1'b1;
                     state    <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               start <= 1'b0;
               wcnt  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               // done wins over a timeout landing on the same cycle.
               if (done) begin
                  issue_count <= issue_count + 8'd1;
                  state       <= S_IDLE;
               end else if (wcnt == TLAST) begin
                  err_timeout <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
